// File: rtl/mbist_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mbist_seq_if
//  Description : Bundle of the CPU register port and the per-engine memory
//                BIST handshake used by mbist_seq. The slave modport is the
//                sequencer side; the master modport is the CPU/engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mbist_seq_if #(
   parameter int NUM_MEM = 9
) ();
   logic               test_enable;
   logic               cpu_wr;
   logic [4:0]         cpu_addr;
   logic [7:0]         cpu_wdata;
   logic [7:0]         cpu_rdata;
   logic [NUM_MEM-1:0] mbist_done;
   logic [NUM_MEM-1:0] mbist_fail;
   logic               mbist_rst;
   logic               mbist_test;
   logic [NUM_MEM-1:0] mbist_start;
   logic               busy;
   logic               irq;

   modport slave (
      input  test_enable, cpu_wr, cpu_addr, cpu_wdata, mbist_done, mbist_fail,
      output cpu_rdata, mbist_rst, mbist_test, mbist_start, busy, irq
   );

   modport master (
      output test_enable, cpu_wr, cpu_addr, cpu_wdata, mbist_done, mbist_fail,
      input  cpu_rdata, mbist_rst, mbist_test, mbist_start, busy, irq
   );
endinterface
`default_nettype wire

// File: rtl/mbist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mbist_seq
//  Description : Memory BIST sequencer for NUM_MEM engines. Runs all engines
//                together (parallel) or one after another (serial), applies a
//                programmable 16-bit timeout, captures per-engine done/fail
//                maps and raises a level interrupt on completion. Control and
//                status live behind a 5-bit address / 8-bit data register
//                port with registered read data.
//                Optional build macro MBIST_SEQ_RETRY_EN: in serial mode an
//                engine that fails is re-run once before its result counts;
//                address 0x18 then reads a saturating retry count.
//  Revision    : 1.0 - initial release
// ============================================================================
module mbist_seq #(
   parameter int          NUM_MEM = 9,
   parameter int          RST_CYC = 4,
   parameter logic [15:0] TO_DEF  = 16'h0400
) (
   input  logic        clock,
   input  logic        reset,
   mbist_seq_if.slave  bus
);

   localparam int               c_IW       = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
   localparam logic [c_IW-1:0]  c_LAST     = c_IW'(NUM_MEM - 1);
   localparam logic [3:0]       c_RST_LAST = 4'(RST_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RUN  = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state;
   logic [3:0]         r_rcnt;
   logic [15:0]        r_to_cnt;
   logic [15:0]        r_to_lim;
   logic [c_IW-1:0]    r_idx;
   logic               r_ser_cfg;
   logic               r_ser_run;
   logic               r_irq_en;
   logic               r_pass;
   logic               r_fail;
   logic               r_timeout;
   logic               r_aborted;
   logic               r_irq_pend;
   logic [NUM_MEM-1:0] r_done_map;
   logic [NUM_MEM-1:0] r_fail_map;
   logic               r_mbist_rst;
   logic               r_mbist_test;
   logic [NUM_MEM-1:0] r_mbist_start;
   logic               r_busy;
   logic [7:0]         r_rdata;
`ifdef MBIST_SEQ_RETRY_EN
   logic               r_retried;
   logic [7:0]         r_retry_cnt;
`endif

   logic               w_wr_ctrl;
   logic               w_start_req;
   logic               w_abort_req;
   logic               w_kill;
   logic [15:0]        w_cnt_nxt;
   logic               w_to_hit;
   logic [NUM_MEM-1:0] w_sel;
   logic               w_idx_done;
   logic               w_idx_fail;
   logic [NUM_MEM-1:0] w_run_done_map;
   logic [NUM_MEM-1:0] w_run_fail_map;
   logic               w_finish;
   logic               w_timeout;
   logic               w_advance;
   logic               w_retry;
   logic [63:0]        w_fail64;
   logic [63:0]        w_done64;
   logic [7:0]         w_rdata;

   // Decode CTRL strobes; abort in the same write suppresses start.
   always_comb begin
      w_wr_ctrl   = bus.cpu_wr && (bus.cpu_addr == 5'h00);
      w_abort_req = w_wr_ctrl && bus.cpu_wdata[2];
      w_start_req = w_wr_ctrl && bus.cpu_wdata[0] && !bus.cpu_wdata[2];
      w_kill      = w_abort_req || !bus.test_enable;
   end

   // Saturating timeout counter look-ahead; a zero limit disables the check.
   always_comb begin
      w_cnt_nxt = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
      w_to_hit  = (r_to_lim != 16'h0000) && (w_cnt_nxt == r_to_lim);
   end

   // One-hot select of the engine currently owned in serial mode.
   always_comb begin
      w_sel        = '0;
      w_sel[r_idx] = 1'b1;
      w_idx_done   = |(bus.mbist_done & w_sel);
      w_idx_fail   = |(bus.mbist_fail & w_sel);
   end

   // RUN-state decision: map updates, completion, timeout, advance or retry.
   always_comb begin
      w_run_done_map = r_done_map;
      w_run_fail_map = r_fail_map;
      w_finish       = 1'b0;
      w_timeout      = 1'b0;
      w_advance      = 1'b0;
      w_retry        = 1'b0;
      if (!r_ser_run) begin
         w_run_done_map = r_done_map | bus.mbist_done;
         w_run_fail_map = r_fail_map | (bus.mbist_done & bus.mbist_fail);
         // An engine finishing on the timeout cycle still counts as done.
         if (&w_run_done_map) begin
            w_finish = 1'b1;
         end else if (w_to_hit) begin
            w_finish       = 1'b1;
            w_timeout      = 1'b1;
            w_run_fail_map = w_run_fail_map | ~w_run_done_map;
         end
      end else begin
         if (w_idx_done) begin
`ifdef MBIST_SEQ_RETRY_EN
            if (w_idx_fail && !r_retried) begin
               w_retry = 1'b1;
            end else begin
`else
            begin
`endif
               w_run_done_map = r_done_map | w_sel;
               w_run_fail_map = r_fail_map | (w_sel & bus.mbist_fail);
               if (r_idx == c_LAST) begin
                  w_finish = 1'b1;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end else if (w_to_hit) begin
            w_finish       = 1'b1;
            w_timeout      = 1'b1;
            w_run_fail_map = r_fail_map | ~r_done_map;
         end
      end
   end

   // Zero-extend the maps so byte windows above NUM_MEM read as 0.
   always_comb begin
      w_fail64              = '0;
      w_done64              = '0;
      w_fail64[NUM_MEM-1:0] = r_fail_map;
      w_done64[NUM_MEM-1:0] = r_done_map;
   end

   // Register read multiplexer; unmapped addresses return 0.
   always_comb begin
      w_rdata = 8'h00;
      if (bus.cpu_addr == 5'h00) begin
         w_rdata = {4'b0000, r_irq_en, 1'b0, r_ser_cfg, 1'b0};
      end else if (bus.cpu_addr == 5'h01) begin
         w_rdata = {2'b00, r_irq_pend, r_aborted, r_timeout, r_fail, r_pass, r_busy};
      end else if (bus.cpu_addr == 5'h02) begin
         w_rdata = r_to_lim[7:0];
      end else if (bus.cpu_addr == 5'h03) begin
         w_rdata = r_to_lim[15:8];
      end else if (bus.cpu_addr[4:3] == 2'b01) begin
         w_rdata = w_fail64[{bus.cpu_addr[2:0], 3'b000} +: 8];
      end else if (bus.cpu_addr[4:3] == 2'b10) begin
         w_rdata = w_done64[{bus.cpu_addr[2:0], 3'b000} +: 8];
`ifdef MBIST_SEQ_RETRY_EN
      end else if (bus.cpu_addr == 5'h18) begin
         w_rdata = r_retry_cnt;
`endif
      end
   end

   // Sequencer FSM, register file and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_rcnt        <= 4'd0;
         r_to_cnt      <= 16'd0;
         r_to_lim      <= TO_DEF;
         r_idx         <= '0;
         r_ser_cfg     <= 1'b0;
         r_ser_run     <= 1'b0;
         r_irq_en      <= 1'b0;
         r_pass        <= 1'b0;
         r_fail        <= 1'b0;
         r_timeout     <= 1'b0;
         r_aborted     <= 1'b0;
         r_irq_pend    <= 1'b0;
         r_done_map    <= '0;
         r_fail_map    <= '0;
         r_mbist_rst   <= 1'b0;
         r_mbist_test  <= 1'b0;
         r_mbist_start <= '0;
         r_busy        <= 1'b0;
         r_rdata       <= 8'h00;
`ifdef MBIST_SEQ_RETRY_EN
         r_retried     <= 1'b0;
         r_retry_cnt   <= 8'h00;
`endif
      end else begin
         r_rdata <= w_rdata;

         if (bus.cpu_wr) begin
            case (bus.cpu_addr)
               5'h00: begin
                  r_ser_cfg <= bus.cpu_wdata[1];
                  r_irq_en  <= bus.cpu_wdata[3];
               end
               5'h01: if (bus.cpu_wdata[5]) r_irq_pend <= 1'b0;
               5'h02: r_to_lim[7:0]  <= bus.cpu_wdata;
               5'h03: r_to_lim[15:8] <= bus.cpu_wdata;
               default: ;
            endcase
         end

         if (r_busy && w_kill) begin
            // Abort: drop every engine strobe at once, results stay cleared.
            r_state       <= S_IDLE;
            r_mbist_rst   <= 1'b0;
            r_mbist_test  <= 1'b0;
            r_mbist_start <= '0;
            r_busy        <= 1'b0;
            r_aborted     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: begin
                  if (w_start_req && bus.test_enable) begin
                     r_state       <= S_RST;
                     r_rcnt        <= 4'd0;
                     r_idx         <= '0;
                     r_ser_run     <= bus.cpu_wdata[1];
                     r_mbist_rst   <= 1'b1;
                     r_mbist_test  <= 1'b1;
                     r_mbist_start <= '0;
                     r_busy        <= 1'b1;
                     r_pass        <= 1'b0;
                     r_fail        <= 1'b0;
                     r_timeout     <= 1'b0;
                     r_aborted     <= 1'b0;
                     r_done_map    <= '0;
                     r_fail_map    <= '0;
`ifdef MBIST_SEQ_RETRY_EN
                     r_retried     <= 1'b0;
                     r_retry_cnt   <= 8'h00;
`endif
                  end
               end
               S_RST: begin
                  if (r_rcnt == c_RST_LAST) begin
                     r_state       <= S_RUN;
                     r_mbist_rst   <= 1'b0;
                     r_to_cnt      <= 16'd0;
                     r_mbist_start <= r_ser_run ? w_sel : {NUM_MEM{1'b1}};
                  end else begin
                     r_rcnt <= r_rcnt + 4'd1;
                  end
               end
               S_RUN: begin
                  r_done_map <= w_run_done_map;
                  r_fail_map <= w_run_fail_map;
                  if (w_finish) begin
                     r_state       <= S_DONE;
                     r_mbist_start <= '0;
                     r_mbist_test  <= 1'b0;
                     r_busy        <= 1'b0;
                     r_timeout     <= w_timeout;
                     r_pass        <= (w_run_fail_map == '0) && !w_timeout;
                     r_fail        <= !((w_run_fail_map == '0) && !w_timeout);
                     // Placed after the W1C decode so a same-cycle clear loses.
                     r_irq_pend    <= 1'b1;
                  end else if (w_advance || w_retry) begin
                     r_state       <= S_GAP;
                     r_mbist_start <= '0;
                     if (w_advance) r_idx <= r_idx + c_IW'(1);
`ifdef MBIST_SEQ_RETRY_EN
                     r_retried <= w_retry;
                     if (w_retry && (r_retry_cnt != 8'hFF)) begin
                        r_retry_cnt <= r_retry_cnt + 8'd1;
                     end
`endif
                  end else begin
                     r_to_cnt <= w_cnt_nxt;
                  end
               end
               S_GAP: begin
                  // One idle cycle with start low, then re-reset the engines.
                  r_state     <= S_RST;
                  r_rcnt      <= 4'd0;
                  r_mbist_rst <= 1'b1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.cpu_rdata   = r_rdata;
   assign bus.mbist_rst   = r_mbist_rst;
   assign bus.mbist_test  = r_mbist_test;
   assign bus.mbist_start = r_mbist_start;
   assign bus.busy        = r_busy;
   assign bus.irq         = r_irq_pend & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_mbist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mbist_seq
//  Description : Directed self-checking bench for mbist_seq (NUM_MEM=9,
//                RST_CYC=4). Covers parallel pass, serial walk with a failing
//                engine, timeout, abort, start gating, W1C, optional retry
//                (MBIST_SEQ_RETRY_EN) and asynchronous reset mid-run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mbist_seq;

   localparam int NM = 9;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   mbist_seq_if #(.NUM_MEM(NM)) bus ();

   mbist_seq #(
      .NUM_MEM (NM),
      .RST_CYC (4),
      .TO_DEF  (16'h0400)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      bus.cpu_wr    = 1'b1;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      tick();
      bus.cpu_wr    = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      bus.cpu_addr = a;
      tick();
      d = bus.cpu_rdata;
   endtask

   // Wait for the engine's start, check the one-hot and the preceding reset
   // pulse length, then report done (with fail if f) after two run cycles.
   task automatic rse(input int i, input bit f);
      logic [NM-1:0] one_v;
      int            n_rst;
      int            k;
      one_v = 1;
      n_rst = 0;
      k     = 0;
      while ((bus.mbist_start == '0) && (k < 60)) begin
         if (bus.mbist_rst) n_rst++;
         tick();
         k++;
      end
      chk("ser_start", bus.mbist_start, one_v << i);
      chk("ser_rst_len", n_rst, 4);
      tick();
      tick();
      bus.mbist_done = one_v << i;
      bus.mbist_fail = f ? (one_v << i) : '0;
      tick();
      chk("ser_start_drop", bus.mbist_start, 0);
      bus.mbist_done = '0;
      bus.mbist_fail = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      int         n;

      bus.test_enable = 1'b0;
      bus.cpu_wr      = 1'b0;
      bus.cpu_addr    = 5'h00;
      bus.cpu_wdata   = 8'h00;
      bus.mbist_done  = '0;
      bus.mbist_fail  = '0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      chk("rst_outs", {bus.mbist_rst, bus.mbist_test, bus.mbist_start, bus.busy, bus.irq}, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      rst_n = 1'b1;
      tick();
      rd(5'h01, d); chk("rst_status", d, 8'h00);
      rd(5'h02, d); chk("rst_to_lo", d, 8'h00);
      rd(5'h03, d); chk("rst_to_hi", d, 8'h04);

      // ---------------- parallel pass ----------------
      bus.test_enable = 1'b1;
      wr(5'h00, 8'h09);
      chk("par_busy", bus.busy, 1);
      chk("par_test", bus.mbist_test, 1);
      n = 0;
      while (bus.mbist_rst && (n < 20)) begin
         n++;
         tick();
      end
      chk("par_rst_len", n, 4);
      chk("par_start", bus.mbist_start, 9'h1FF);
      tick();
      tick();
      bus.mbist_done = 9'h1FF;
      bus.mbist_fail = '0;
      tick();
      chk("par_done_outs", {bus.busy, bus.mbist_start, bus.mbist_test}, 0);
      chk("par_irq", bus.irq, 1);
      bus.mbist_done = '0;
      rd(5'h01, d); chk("par_status", d, 8'h22);
      rd(5'h08, d); chk("par_fail0", d, 8'h00);
      rd(5'h09, d); chk("par_fail1", d, 8'h00);
      rd(5'h10, d); chk("par_done0", d, 8'hFF);
      rd(5'h11, d); chk("par_done1", d, 8'h01);
      rd(5'h12, d); chk("par_done2_above", d, 8'h00);
      rd(5'h00, d); chk("par_ctrl", d, 8'h08);

      // ---------------- W1C of irq_pend ----------------
      wr(5'h01, 8'h20);
      chk("w1c_irq", bus.irq, 0);
      rd(5'h01, d); chk("w1c_status", d, 8'h02);

      // ---------------- start gating ----------------
      bus.test_enable = 1'b0;
      wr(5'h00, 8'h01);
      tick();
      chk("gate_outs", {bus.busy, bus.mbist_rst, bus.mbist_test}, 0);
      rd(5'h01, d); chk("gate_status", d, 8'h02);

      // ---------------- serial with engine 3 failing ----------------
      bus.test_enable = 1'b1;
      wr(5'h00, 8'h0B);
      for (int i = 0; i < NM; i++) begin
         rse(i, i == 3);
`ifdef MBIST_SEQ_RETRY_EN
         if (i == 3) rse(3, 1'b1);
`endif
      end
      chk("ser_busy", bus.busy, 0);
      chk("ser_irq", bus.irq, 1);
      rd(5'h01, d); chk("ser_status", d, 8'h24);
      rd(5'h08, d); chk("ser_fail0", d, 8'h08);
      rd(5'h09, d); chk("ser_fail1", d, 8'h00);
      rd(5'h11, d); chk("ser_done1", d, 8'h01);

      // ---------------- timeout ----------------
      wr(5'h01, 8'h20);
      wr(5'h02, 8'h10);
      wr(5'h03, 8'h00);
      wr(5'h00, 8'h09);
      repeat (4) tick();
      bus.mbist_done = 9'h0FF;
      bus.mbist_fail = '0;
      repeat (15) tick();
      chk("to_busy_before", bus.busy, 1);
      tick();
      chk("to_busy_after", bus.busy, 0);
      bus.mbist_done = '0;
      rd(5'h01, d); chk("to_status", d, 8'h2C);
      rd(5'h08, d); chk("to_fail0", d, 8'h00);
      rd(5'h09, d); chk("to_fail1", d, 8'h01);
      rd(5'h11, d); chk("to_done1", d, 8'h00);

      // ---------------- TO=0 disables timeout, then abort ----------------
      wr(5'h01, 8'h20);
      wr(5'h02, 8'h00);
      wr(5'h03, 8'h00);
      wr(5'h00, 8'h09);
      repeat (40) tick();
      chk("ab_still_busy", bus.busy, 1);
      chk("ab_start_on", bus.mbist_start, 9'h1FF);
      bus.test_enable = 1'b0;
      tick();
      chk("ab_outs", {bus.busy, bus.mbist_start, bus.mbist_test, bus.mbist_rst}, 0);
      chk("ab_irq", bus.irq, 0);
      rd(5'h01, d); chk("ab_status", d, 8'h10);

      // ---------------- start + abort in one write ----------------
      bus.test_enable = 1'b1;
      wr(5'h00, 8'h05);
      tick();
      chk("sa_busy", bus.busy, 0);
      rd(5'h01, d); chk("sa_status", d, 8'h10);

`ifdef MBIST_SEQ_RETRY_EN
      // ---------------- retry: engine 2 fails once ----------------
      wr(5'h00, 8'h0B);
      for (int i = 0; i < NM; i++) begin
         rse(i, i == 2);
         if (i == 2) rse(2, 1'b0);
      end
      rd(5'h01, d); chk("rt_status", d, 8'h22);
      rd(5'h08, d); chk("rt_fail0", d, 8'h00);
      rd(5'h18, d); chk("rt_count", d, 8'h01);
`else
      rd(5'h18, d); chk("no_retry_reg", d, 8'h00);
`endif

      // ---------------- asynchronous reset mid-run ----------------
      wr(5'h00, 8'h01);
      repeat (6) tick();
      chk("ar_running", bus.busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_outs", {bus.mbist_rst, bus.mbist_test, bus.mbist_start, bus.busy, bus.irq}, 0);
      tick();
      rst_n = 1'b1;
      rd(5'h01, d); chk("ar_status", d, 8'h00);
      rd(5'h03, d); chk("ar_to_hi", d, 8'h04);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
